lsu_rmw: RTL

//  Load/store unit sitting directly upstream of the data memory (DM: word-wide,

---
 rtl/lsu_rmw_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_rmw.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_rmw_pkg.sv
// ============================================================================
// Module : lsu_rmw_pkg
// Brief  : Shared funct3 encodings, FSM state type and request-check helpers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_rmw_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    function automatic logic req_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 > F3_W;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Access size comes from funct3[1:0] for both loads and stores.
    function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane extract (loads) and lane merge (SB/SH RMW)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_rmw_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rd,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_rdata,
    output logic [XLEN-1:0] o_wd
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rd[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rd[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_rdata = i_rd;
        case (i_funct3)
            F3_B:    o_rdata = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    o_rdata = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   o_rdata = {{(XLEN-16){1'b0}}, w_half};
            default: o_rdata = i_rd;
        endcase
    end

    // Store funct3 SB/SH share encodings with LB/LH.
    always_comb begin
        o_wd = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_wd = i_rd;
                o_wd[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_H: begin
                o_wd = i_rd;
                o_wd[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: o_wd = i_wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_rmw.sv
// ============================================================================
// Module : lsu_rmw
// Brief  : RV32I load/store unit with read-modify-write for SB/SH on a DM
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int AW   = 5,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [AW-1:0]   addressDM,
    output logic [XLEN-1:0] wd,
    output logic            we,
    input  logic [XLEN-1:0] rd
);

    lsu_state_t      r_state;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic [AW-1:0]   r_word;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_wd;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_err;
    logic [XLEN-1:0] w_ext_rdata;
    logic [XLEN-1:0] w_merged_wd;

    assign w_err = (|req_addr[31:AW+2])
                 | req_illegal(req_we, req_funct3)
                 | req_misaligned(req_funct3, req_addr[1:0]);

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .i_rd      (rd),
        .i_wdata   (r_wdata),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_rdata   (w_ext_rdata),
        .o_wd      (w_merged_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_wd      <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        r_word    <= req_addr[AW+1:2];
                        r_wdata   <= req_wdata;
                        r_err     <= w_err;
                        if (w_err) begin
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end else if (!req_we) begin
                            r_state <= ST_LOAD;
                        end else if (req_funct3 == F3_W) begin
                            r_wd    <= req_wdata;
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rdata <= w_ext_rdata;
                    r_state <= ST_RESP;
                end
                ST_RMW_RD: begin
                    r_wd    <= w_merged_wd;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // rdata only changes on the edge that opens a response
                    r_rdata <= '0;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign we         = (r_state == ST_WRITE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = r_err && (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign addressDM  = r_word;
    assign wd         = r_wd;

endmodule

`default_nettype wire
